keypad_scan_ctrl: RTL

//   Parametrised matrix-keypad scanner: drives rows one-hot and samples cols through an internal 2-flop synchronizer.

---
 rtl/keypad_pkg.sv | 13 +
 rtl/keypad_scan_ctrl_sync_2ff.sv | 14 +
 rtl/keypad_scan_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM state type and width helpers for the keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DB_PRESS, HELD, DB_REL} kp_state_t;
  function automatic int cnt_w(input int max);
    return max < 1 ? 1 : $clog2(max + 1);
  endfunction
  function automatic int idx_w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
  function automatic int code_w(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction
endpackage

// File: rtl/keypad_scan_ctrl_sync_2ff.sv
// sync_2ff: two-flop synchronizer with asynchronous active-high reset to zero
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= '0;
    else {q, m} <= {m, d};
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: matrix keypad scanner with debounce, auto-repeat and valid/ready key events
module keypad_scan_ctrl import keypad_pkg::*; #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_CYCLES   = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [COLS-1:0]               async_col,
  input  logic                          repeat_en,
  input  logic                          key_ready,
  output logic [ROWS-1:0]               row,
  output logic                          key_valid,
  output logic [$clog2(ROWS*COLS)-1:0]  key_code,
  output logic                          overrun
);
  localparam int CW = code_w(ROWS, COLS);
  localparam int RW = idx_w(ROWS);
  localparam int LW = idx_w(COLS);
  localparam int SW = cnt_w(SCAN_CYCLES - 1);
  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int PW = cnt_w(REPEAT_CYCLES);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] REP_LAST  = PW'(REPEAT_CYCLES - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0] COLS_C    = CW'(COLS);
  logic [COLS-1:0] col;
  kp_state_t       state, state_n;
  logic [RW-1:0]   row_idx, row_next;
  logic [LW-1:0]   lock_col, low_col;
  logic [SW-1:0]   dwell;
  logic [DW-1:0]   db;
  logic [PW-1:0]   rep;
  logic [CW-1:0]   code;
  logic            sample, any_col, lock_hi, db_done, rep_done, emit;
  sync_2ff #(.W(COLS)) u_sync (
    .clk (clk),
    .rst (reset),
    .d   (async_col),
    .q   (col)
  );
  always_comb begin
    low_col = '0;
    for (int i = COLS - 1; i >= 0; i--) if (col[i]) low_col = LW'(i);
  end
  assign any_col  = |col;
  assign lock_hi  = col[lock_col];
  assign sample   = dwell == SCAN_LAST;
  assign db_done  = db >= DB_LAST;
  assign rep_done = rep >= REP_LAST;
  assign row_next = row_idx == ROW_LAST ? '0 : row_idx + 1'b1;
  assign row      = ROWS'(1) << row_idx;
  assign code     = CW'(row_idx) * COLS_C + CW'(lock_col);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= SCAN;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      SCAN:     state_n = sample && any_col ? DB_PRESS : SCAN;
      DB_PRESS: state_n = !lock_hi ? SCAN : db_done ? HELD : DB_PRESS;
      HELD:     state_n = lock_hi ? HELD : DB_REL;
      DB_REL:   state_n = lock_hi ? HELD : db_done ? SCAN : DB_REL;
      default:  state_n = SCAN;
    endcase
  end
  always_comb begin
    emit = 1'b0;
    emit = (state == DB_PRESS && lock_hi && db_done) ||
           (state == HELD && lock_hi && repeat_en && rep_done);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      row_idx  <= '0;
      lock_col <= '0;
      dwell    <= '0;
      db       <= '0;
      rep      <= '0;
    end else begin
      dwell <= state == SCAN && !sample ? dwell + 1'b1 : '0;
      db    <= ((state == DB_PRESS && lock_hi) || (state == DB_REL && !lock_hi)) && !db_done ? db + 1'b1 : '0;
      rep   <= state == HELD && lock_hi && repeat_en && !rep_done ? rep + 1'b1 : '0;
      if (state == SCAN && sample && any_col) lock_col <= low_col;
      if ((state == SCAN && sample && !any_col) || (state == DB_REL && !lock_hi && db_done)) row_idx <= row_next;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      overrun   <= 1'b0;
    end else if (emit && (!key_valid || key_ready)) begin
      key_valid <= 1'b1;
      key_code  <= code;
    end else if (emit) begin
      overrun <= 1'b1;
    end else if (key_ready) begin
      key_valid <= 1'b0;
    end
endmodule
